demod_acc: RTL and testbench

DEMOD_ACC -- requirements
Module: demod_acc

---
 rtl/demod_pkg.sv | 30 +++
 rtl/lane_sum.sv | 58 +++++
 rtl/demod_acc.sv | 170 +++++++++++++++++
 tb/tb_demod_acc.sv | 372 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/demod_pkg.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module  : demod_pkg
// Purpose : Shared definitions for the demodulator window accumulator:
//           default sizing constants, the control-FSM state type and the
//           accumulator width derivation.
// Ports   : (package, no ports)
// Revision: 1.0 - initial release
// ============================================================================
package demod_pkg;

  localparam int DEF_DWIDTH = 14;
  localparam int DEF_CWIDTH = 11;
  localparam int DEF_UNR    = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACC   = 2'd1,
    FLUSH = 2'd2
  } state_e;

  // Lane width (DWIDTH+1) plus growth for UNR lanes per beat and up to
  // 2^CWIDTH-1 beats per window, so a full window can never overflow.
  function automatic int awidth(input int dwidth, input int cwidth, input int unr);
    return dwidth + 1 + cwidth + $clog2(unr);
  endfunction

endpackage
`default_nettype wire

// File: rtl/lane_sum.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module  : lane_sum
// Purpose : Registered signed sum of UNR lanes of one beat, sign-extended to
//           SWIDTH bits, with a matching valid flag (pipeline stage 1).
// Ports   : clk       - clock
//           reset_n   - asynchronous active-low reset
//           din_i     - UNR signed lanes, DWIDTH+1 bits each
//           valid_i   - beat accepted this cycle
//           sum_o     - registered lane sum
//           valid_o   - sum_o holds the sum of a beat accepted last cycle
// Revision: 1.0 - initial release
// ============================================================================
module lane_sum
  import demod_pkg::*;
#(
  parameter int DWIDTH = DEF_DWIDTH,
  parameter int UNR    = DEF_UNR,
  parameter int SWIDTH = DWIDTH + 1 + $clog2(UNR)
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic signed [DWIDTH:0]   din_i [UNR],
  input  logic                     valid_i,
  output logic signed [SWIDTH-1:0] sum_o,
  output logic                     valid_o
);

  logic signed [SWIDTH-1:0] sum_d;
  logic signed [SWIDTH-1:0] sum_q;
  logic                     valid_q;

  always_comb begin
    sum_d = '0;
    for (int i = 0; i < UNR; i++) begin
      sum_d = sum_d + SWIDTH'(din_i[i]);
    end
  end

  // The sum register only loads on accepted beats; valid_q qualifies it.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sum_q   <= '0;
      valid_q <= 1'b0;
    end else begin
      valid_q <= valid_i;
      if (valid_i) begin
        sum_q <= sum_d;
      end
    end
  end

  assign sum_o   = sum_q;
  assign valid_o = valid_q;

endmodule
`default_nettype wire

// File: rtl/demod_acc.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module  : demod_acc
// Purpose : Windowed accumulator for fs/4 demodulated samples. A start
//           request opens a window of acq_len beats; every accepted beat's
//           lanes are summed (stage 1) and accumulated (stage 2). The window
//           total appears on dout with a one-cycle dout_valid pulse two
//           cycles after the final beat.
// Config  : DEMOD_ACC_CONT_EN - when defined, the block re-arms after each
//           window with the same latched length and accepts a beat during
//           FLUSH as the first beat of the next window (busy stays high).
// Ports   : clk        - clock
//           reset_n    - asynchronous active-low reset
//           din        - UNR signed lanes, DWIDTH+1 bits each
//           din_valid  - din carries a beat this cycle
//           start      - single-cycle window request
//           acq_len    - beats per window (0 = request ignored)
//           busy       - high while not IDLE
//           dout       - signed window sum, AWIDTH bits
//           dout_valid - one-cycle pulse marking a new dout
// Revision: 1.0 - initial release
// ============================================================================
module demod_acc
  import demod_pkg::*;
#(
  parameter  int DWIDTH = DEF_DWIDTH,
  parameter  int CWIDTH = DEF_CWIDTH,
  parameter  int UNR    = DEF_UNR,
  localparam int AWIDTH = awidth(DWIDTH, CWIDTH, UNR)
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic signed [DWIDTH:0]   din [UNR],
  input  logic                     din_valid,
  input  logic                     start,
  input  logic [CWIDTH-1:0]        acq_len,
  output logic                     busy,
  output logic signed [AWIDTH-1:0] dout,
  output logic                     dout_valid
);

  state_e                   state_q, state_d;
  logic [CWIDTH-1:0]        len_q, len_d;
  logic [CWIDTH-1:0]        cnt_q, cnt_d;
  logic [CWIDTH-1:0]        beat_num;
  logic                     beat_last;
  logic                     accept;

  logic signed [AWIDTH-1:0] s1_sum;
  logic                     s1_valid;
  logic                     s1_first_q;
  logic                     s1_last_q;

  logic signed [AWIDTH-1:0] acc_q, acc_d;
  logic signed [AWIDTH-1:0] dout_q, dout_d;
  logic                     dv_q, dv_d;

  // --------------------------------------------------------------------------
  // Control FSM. cnt_q holds beats accepted so far in the current window and
  // is cleared on the final beat, so it is already zero in FLUSH.
  // --------------------------------------------------------------------------
  always_comb begin
    state_d   = state_q;
    len_d     = len_q;
    cnt_d     = cnt_q;
    accept    = 1'b0;
    beat_num  = cnt_q + CWIDTH'(1);
    beat_last = (beat_num == len_q);

    case (state_q)
      IDLE: begin
        if (start && (acq_len != '0)) begin
          state_d = ACC;
          len_d   = acq_len;
          cnt_d   = '0;
        end
      end
      ACC: begin
        accept = din_valid;
        if (accept) begin
          cnt_d = beat_last ? '0 : beat_num;
          if (beat_last) begin
            state_d = FLUSH;
          end
        end
      end
      FLUSH: begin
`ifdef DEMOD_ACC_CONT_EN
        // A beat here opens the next window; with a length of one it is also
        // that window's final beat, so FLUSH repeats.
        accept  = din_valid;
        state_d = ACC;
        if (accept) begin
          cnt_d = beat_last ? '0 : beat_num;
          if (beat_last) begin
            state_d = FLUSH;
          end
        end
`else
        state_d = IDLE;
`endif
      end
      default: state_d = IDLE;
    endcase
  end

  // --------------------------------------------------------------------------
  // Stage 1: lane adder, with first/last-of-window tags travelling alongside.
  // --------------------------------------------------------------------------
  lane_sum #(
    .DWIDTH (DWIDTH),
    .UNR    (UNR),
    .SWIDTH (AWIDTH)
  ) u_lane_sum (
    .clk     (clk),
    .reset_n (reset_n),
    .din_i   (din),
    .valid_i (accept),
    .sum_o   (s1_sum),
    .valid_o (s1_valid)
  );

  // --------------------------------------------------------------------------
  // Stage 2: the first beat loads the accumulator so no separate clear is
  // needed between windows; the last beat publishes the total.
  // --------------------------------------------------------------------------
  always_comb begin
    acc_d  = acc_q;
    dout_d = dout_q;
    dv_d   = 1'b0;
    if (s1_valid) begin
      acc_d = s1_first_q ? s1_sum : (acc_q + s1_sum);
      if (s1_last_q) begin
        dout_d = acc_d;
        dv_d   = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= IDLE;
      len_q      <= '0;
      cnt_q      <= '0;
      s1_first_q <= 1'b0;
      s1_last_q  <= 1'b0;
      acc_q      <= '0;
      dout_q     <= '0;
      dv_q       <= 1'b0;
    end else begin
      state_q <= state_d;
      len_q   <= len_d;
      cnt_q   <= cnt_d;
      if (accept) begin
        s1_first_q <= (cnt_q == '0);
        s1_last_q  <= beat_last;
      end
      acc_q   <= acc_d;
      dout_q  <= dout_d;
      dv_q    <= dv_d;
    end
  end

  assign busy       = (state_q != IDLE);
  assign dout       = dout_q;
  assign dout_valid = dv_q;

endmodule
`default_nettype wire

// File: tb/tb_demod_acc.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module  : tb_demod_acc
// Purpose : Self-checking bench for demod_acc. Expected window sums come from
//           a plain arithmetic model over the beats the bench presents.
//           Build with DEMOD_ACC_CONT_EN to exercise continuous mode.
// Revision: 1.0 - initial release
// ============================================================================
module tb_demod_acc;

  localparam int DW = 14;
  localparam int CW = 11;
  localparam int U  = 4;
  localparam int AW = 28;

  typedef int lanes_t [U];

  logic                 clk = 1'b0;
  logic                 reset_n;
  logic signed [DW:0]   din [U];
  logic                 din_valid;
  logic                 start;
  logic [CW-1:0]        acq_len;
  logic                 busy;
  logic signed [AW-1:0] dout;
  logic                 dout_valid;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  lanes_t beat_q[$];
  bit     vld_q[$];

  always #5 clk = ~clk;

  demod_acc #(
    .DWIDTH (DW),
    .CWIDTH (CW),
    .UNR    (U)
  ) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .din        (din),
    .din_valid  (din_valid),
    .start      (start),
    .acq_len    (acq_len),
    .busy       (busy),
    .dout       (dout),
    .dout_valid (dout_valid)
  );

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached, total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  function automatic lanes_t rand_lanes();
    lanes_t l;
    for (int i = 0; i < U; i++) l[i] = int'($urandom_range(32767)) - 16384;
    return l;
  endfunction

  task automatic set_din(input lanes_t l);
    for (int i = 0; i < U; i++) din[i] = l[i][DW:0];
  endtask

  task automatic idle_inputs();
    din_valid = 1'b0;
    start     = 1'b0;
    set_din(rand_lanes());
  endtask

  function automatic longint lane_total(input lanes_t l);
    longint s = 0;
    for (int i = 0; i < U; i++) s += l[i];
    return s;
  endfunction

  task automatic push_beat(input lanes_t l, input bit v);
    beat_q.push_back(l);
    vld_q.push_back(v);
  endtask

  // Opens a window of len beats and plays the queued beat/valid pattern,
  // whose last entry is the final valid beat.
  task automatic drive_window(input int len, input string name);
    longint exp_sum = 0;
    int     n_acc   = 0;
    foreach (vld_q[i]) begin
      if (vld_q[i] && n_acc < len) begin
        n_acc++;
        exp_sum += lane_total(beat_q[i]);
      end
    end
    start   = 1'b1;
    acq_len = CW'(len);
    step();
    start   = 1'b0;
    acq_len = CW'($urandom);
    total++;
    if (busy !== 1'b1) begin
      bad++;
      $display("FAIL %s busy_after_start: busy=%b expected 1", name, busy);
    end
    for (int i = 0; i < vld_q.size(); i++) begin
      din_valid = vld_q[i];
      set_din(vld_q[i] ? beat_q[i] : rand_lanes());
      step();
      total++;
      if (dout_valid !== 1'b0 || busy !== 1'b1) begin
        bad++;
        $display("FAIL %s in_window cycle %0d: dout_valid=%b busy=%b expected dout_valid=0 busy=1",
                 name, i, dout_valid, busy);
      end
    end
    idle_inputs();
    step();
    total++;
    if (dout_valid !== 1'b1 || dout !== AW'(exp_sum)) begin
      bad++;
      $display("FAIL %s result: dout=%0d dout_valid=%b expected dout=%0d dout_valid=1",
               name, dout, dout_valid, exp_sum);
    end
    step();
    total++;
    if (dout_valid !== 1'b0 || busy !== 1'b0 || dout !== AW'(exp_sum)) begin
      bad++;
      $display("FAIL %s hold: dout=%0d dout_valid=%b busy=%b expected dout=%0d dout_valid=0 busy=0",
               name, dout, dout_valid, busy, exp_sum);
    end
    beat_q.delete();
    vld_q.delete();
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    step();
    start   = 1'b1;
    acq_len = CW'(5);
    step();
    total++;
    if (busy !== 1'b0) begin bad++; $display("FAIL reset busy: busy=%b expected 0", busy); end
    total++;
    if (dout !== '0) begin bad++; $display("FAIL reset dout: dout=%0d expected 0", dout); end
    total++;
    if (dout_valid !== 1'b0) begin bad++; $display("FAIL reset dout_valid: got %b expected 0", dout_valid); end
    start   = 1'b0;
    reset_n = 1'b1;
    step();
    step();
    total++;
    if (busy !== 1'b0) begin bad++; $display("FAIL reset release_busy: busy=%b expected 0", busy); end
  endtask

`ifndef DEMOD_ACC_CONT_EN
  task automatic test_basic();
    lanes_t l = '{1000, 0, -200, 0};
    for (int i = 0; i < 4; i++) push_beat(l, 1'b1);
    drive_window(4, "basic");
    total++;
    if (dout !== 28'sd3200) begin bad++; $display("FAIL basic literal: dout=%0d expected 3200", dout); end
  endtask

  task automatic test_extremes();
    lanes_t lp = '{16383, 16383, 16383, 16383};
    lanes_t ln = '{-16384, -16384, -16384, -16384};
    for (int i = 0; i < 2047; i++) push_beat(lp, 1'b1);
    drive_window(2047, "max_pos");
    total++;
    if (dout !== 28'sd134144004) begin bad++; $display("FAIL max_pos literal: dout=%0d expected 134144004", dout); end
    for (int i = 0; i < 2047; i++) push_beat(ln, 1'b1);
    drive_window(2047, "max_neg");
    total++;
    if (dout !== -28'sd134152192) begin bad++; $display("FAIL max_neg literal: dout=%0d expected -134152192", dout); end
  endtask

  task automatic test_gaps();
    lanes_t l = '{10, 0, -4, 0};
    bit     pat [6] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
    for (int i = 0; i < 6; i++) push_beat(pat[i] ? l : rand_lanes(), pat[i]);
    drive_window(3, "gaps");
    total++;
    if (dout !== 28'sd18) begin bad++; $display("FAIL gaps literal: dout=%0d expected 18", dout); end
  endtask

  task automatic test_start_ignored();
    lanes_t a = rand_lanes();
    lanes_t b = rand_lanes();
    lanes_t c = rand_lanes();
    longint exp_sum = lane_total(a) + lane_total(b) + lane_total(c);
    start   = 1'b1;
    acq_len = '0;
    step();
    start   = 1'b0;
    for (int i = 0; i < 4; i++) begin
      step();
      total++;
      if (busy !== 1'b0 || dout_valid !== 1'b0) begin
        bad++;
        $display("FAIL zero_len: busy=%b dout_valid=%b expected 0 0", busy, dout_valid);
      end
    end
    start = 1'b1; acq_len = CW'(3);
    step();
    start = 1'b0;
    din_valid = 1'b1; set_din(a);
    step();
    set_din(b); start = 1'b1; acq_len = CW'(5);
    step();
    start = 1'b0; set_din(c);
    step();
    total++;
    if (busy !== 1'b1 || dout_valid !== 1'b0) begin
      bad++;
      $display("FAIL restart flush: busy=%b dout_valid=%b expected 1 0", busy, dout_valid);
    end
    idle_inputs();
    step();
    total++;
    if (dout_valid !== 1'b1 || dout !== AW'(exp_sum)) begin
      bad++;
      $display("FAIL restart result: dout=%0d dout_valid=%b expected dout=%0d dout_valid=1",
               dout, dout_valid, exp_sum);
    end
    step();
    total++;
    if (busy !== 1'b0) begin bad++; $display("FAIL restart idle: busy=%b expected 0", busy); end
  endtask

  task automatic test_idle_beats();
    for (int i = 0; i < 5; i++) begin
      din_valid = 1'b1;
      set_din(rand_lanes());
      step();
      total++;
      if (dout_valid !== 1'b0 || busy !== 1'b0) begin
        bad++;
        $display("FAIL idle_beats: dout_valid=%b busy=%b expected 0 0", dout_valid, busy);
      end
    end
    idle_inputs();
    for (int i = 0; i < 3; i++) push_beat(rand_lanes(), 1'b1);
    drive_window(3, "after_idle_beats");
  endtask

  task automatic test_reset_mid();
    lanes_t l = '{1234, -77, 999, 5};
    start = 1'b1; acq_len = CW'(4);
    step();
    start = 1'b0; din_valid = 1'b1; set_din(l);
    step();
    step();
    idle_inputs();
    reset_n = 1'b0;
    #2;
    total++;
    if (busy !== 1'b0 || dout !== '0 || dout_valid !== 1'b0) begin
      bad++;
      $display("FAIL reset_mid clear: busy=%b dout=%0d dout_valid=%b expected 0 0 0", busy, dout, dout_valid);
    end
    step();
    step();
    reset_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      din_valid = 1'b1;
      set_din(l);
      step();
      total++;
      if (dout_valid !== 1'b0 || busy !== 1'b0) begin
        bad++;
        $display("FAIL reset_mid no_pulse: dout_valid=%b busy=%b expected 0 0", dout_valid, busy);
      end
    end
    idle_inputs();
    for (int i = 0; i < 2; i++) push_beat(rand_lanes(), 1'b1);
    drive_window(2, "after_reset_mid");
  endtask

  task automatic test_random();
    for (int w = 0; w < 8; w++) begin
      int len = int'($urandom_range(1, 16));
      int n   = 0;
      while (n < len) begin
        bit v = ($urandom_range(99) < 70);
        push_beat(rand_lanes(), v);
        if (v) n++;
      end
      drive_window(len, "random");
    end
  endtask
`else
  task automatic test_cont();
    int     due_q[$];
    longint val_q[$];
    longint part  = 0;
    int     n_acc = 0;
    start = 1'b1; acq_len = CW'(2);
    step();
    start = 1'b0; acq_len = CW'($urandom);
    for (int i = 0; i < 40; i++) begin
      lanes_t l = rand_lanes();
      bit v = (i < 16) ? 1'b1 : ((i < 32) ? ($urandom_range(99) < 60) : 1'b0);
      din_valid = v;
      set_din(l);
      if (v) begin
        part += lane_total(l);
        n_acc++;
        if (n_acc == 2) begin
          due_q.push_back(cyc + 2);
          val_q.push_back(part);
          part  = 0;
          n_acc = 0;
        end
      end
      step();
      total++;
      if (due_q.size() > 0 && due_q[0] == cyc) begin
        if (dout_valid !== 1'b1 || dout !== AW'(val_q[0])) begin
          bad++;
          $display("FAIL cont result cycle %0d: dout=%0d dout_valid=%b expected dout=%0d dout_valid=1",
                   cyc, dout, dout_valid, val_q[0]);
        end
        void'(due_q.pop_front());
        void'(val_q.pop_front());
      end else if (dout_valid !== 1'b0) begin
        bad++;
        $display("FAIL cont spurious cycle %0d: dout_valid=%b expected 0", cyc, dout_valid);
      end
      total++;
      if (busy !== 1'b1) begin bad++; $display("FAIL cont busy cycle %0d: busy=%b expected 1", cyc, busy); end
    end
    total++;
    if (due_q.size() != 0) begin
      bad++;
      $display("FAIL cont missing: %0d pulses outstanding expected 0", due_q.size());
    end
  endtask
`endif

  initial begin
    reset_n   = 1'b0;
    din_valid = 1'b0;
    start     = 1'b0;
    acq_len   = '0;
    for (int i = 0; i < U; i++) din[i] = '0;
    test_reset();
`ifdef DEMOD_ACC_CONT_EN
    test_cont();
`else
    test_basic();
    test_gaps();
    test_start_ignored();
    test_idle_beats();
    test_random();
    test_extremes();
    test_reset_mid();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
